// File: rtl/fx2_pkg.sv
// Shared types for the FX2 shift/rotate pipe controller: opcodes, the pipeline
// slice record and small helpers used by the hazard and occupancy logic.
package fx2_pkg;

    localparam int FX2_LAT = 4;
    localparam int REG_AW  = 7;
    localparam int FX2_DW  = 128;
    localparam int FX2_OPW = 4;

    typedef enum logic [FX2_OPW-1:0] {
        ROTH   = 4'd0,
        ROT    = 4'd1,
        SHLH   = 4'd2,
        SHL    = 4'd3,
        ROTHM  = 4'd4,
        ROTM   = 4'd5,
        ROTQBY = 4'd6,
        SHLQBY = 4'd7
    } fx2_op_e;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rt;
        fx2_op_e           op;
        logic [FX2_DW-1:0] data;
    } fx2_stage_t;

    localparam int STAGE_W = $bits(fx2_stage_t);

    // A slice only counts as a pending writer when it is live and writes rt.
    function automatic logic stage_hit(input fx2_stage_t s, input logic [REG_AW-1:0] addr);
        return s.valid & s.wr & (s.rt == addr);
    endfunction

    function automatic logic stage_live(input fx2_stage_t s);
        return s.valid;
    endfunction

endpackage

// File: rtl/fx2_stage_reg.sv
// One pipeline slice of the FX2 pipe: holds its record while frozen and
// drops the incoming op's valid bit when killed.
module fx2_stage_reg
    import fx2_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               kill,
    input  logic [STAGE_W-1:0] d,
    output logic [STAGE_W-1:0] q
);

    fx2_stage_t d_s;
    fx2_stage_t nxt_s;
    fx2_stage_t q_r;

    assign d_s = d;
    assign q   = q_r;

    // Next slice contents: the upstream record with its valid masked by kill.
    always_comb begin
        nxt_s       = d_s;
        nxt_s.valid = d_s.valid & ~kill;
    end

    // Slice register: cleared by reset, frozen by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else if (!stall) begin
            q_r <= nxt_s;
        end
    end

endmodule

// File: rtl/fx2_pipe_ctrl.sv
// Issue/sequencing controller for the SPU FX2 pipe: registers operands for the
// external datapath, carries results to writeback and answers RAW hazard queries.
module fx2_pipe_ctrl
    import fx2_pkg::*;
#(
    parameter int LATENCY = FX2_LAT,
    parameter int DW      = FX2_DW,
    parameter int RW      = REG_AW,
    parameter int OPW     = FX2_OPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           iss_valid,
    input  logic [OPW-1:0] iss_op,
    input  logic [RW-1:0]  iss_rt,
    input  logic           iss_wr,
    input  logic [DW-1:0]  iss_ra,
    input  logic [DW-1:0]  iss_rb,
    output logic           iss_ready,
    input  logic           stall,
    input  logic           flush,
    output logic [OPW-1:0] dp_op,
    output logic [DW-1:0]  dp_ra,
    output logic [DW-1:0]  dp_rb,
    input  logic [DW-1:0]  dp_result,
    input  logic [RW-1:0]  chk_ra,
    input  logic [RW-1:0]  chk_rb,
    input  logic [RW-1:0]  chk_rc,
    output logic [2:0]     haz,
    output logic           wb_valid,
    output logic [RW-1:0]  wb_rt,
    output logic [DW-1:0]  wb_data,
    output logic [2:0]     inflight
);

    logic           accept_s;
    logic           hold_s;
    logic           s1_valid_r;
    logic           s1_wr_r;
    logic [RW-1:0]  s1_rt_r;
    logic [OPW-1:0] s1_op_r;
    logic [DW-1:0]  s1_ra_r;
    logic [DW-1:0]  s1_rb_r;
    fx2_stage_t     s2_in_s;
    fx2_stage_t     wb_s;
    logic [STAGE_W-1:0] stg_d_s [2:LATENCY];
    logic [STAGE_W-1:0] stg_q_s [2:LATENCY];
    logic [RW-1:0]  chk_s [3];
    logic [2:0]     haz_s;
    logic [2:0]     killed_s;
    logic [2:0]     retire_s;
    logic [2:0]     inflight_nxt_s;
    logic [2:0]     inflight_r;

    // Flush wins over stall: a flushing cycle still advances the pipe.
    assign iss_ready = ~stall & ~flush;
    assign accept_s  = iss_valid & ~stall & ~flush;
    assign hold_s    = stall & ~flush;

    // Stage 1: operands are only reloaded on accept to keep the datapath quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_wr_r    <= 1'b0;
            s1_rt_r    <= '0;
            s1_op_r    <= '0;
            s1_ra_r    <= '0;
            s1_rb_r    <= '0;
        end else if (!hold_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_wr_r <= iss_wr;
                s1_rt_r <= iss_rt;
                s1_op_r <= iss_op;
                s1_ra_r <= iss_ra;
                s1_rb_r <= iss_rb;
            end
        end
    end

    assign dp_op = s1_op_r;
    assign dp_ra = s1_ra_r;
    assign dp_rb = s1_rb_r;

    // Stage-2 input record: stage-1 control plus the datapath result.
    always_comb begin
        s2_in_s       = '0;
        s2_in_s.valid = s1_valid_r;
        s2_in_s.wr    = s1_wr_r;
        s2_in_s.rt    = s1_rt_r;
        s2_in_s.op    = fx2_op_e'(s1_op_r);
        s2_in_s.data  = dp_result;
    end

    for (genvar k = 2; k <= LATENCY; k++) begin : g_stage
        if (k == 2) begin : g_head
            assign stg_d_s[k] = s2_in_s;
        end else begin : g_link
            assign stg_d_s[k] = stg_q_s[k-1];
        end
        fx2_stage_reg u_stage (
            .clk   (clk),
            .rst   (rst),
            .stall (hold_s),
            .kill  (flush),
            .d     (stg_d_s[k]),
            .q     (stg_q_s[k])
        );
    end

    assign wb_s     = stg_q_s[LATENCY];
    assign wb_valid = wb_s.valid & wb_s.wr;
    assign wb_rt    = wb_s.rt;
    assign wb_data  = wb_s.data;

    assign chk_s[0] = chk_ra;
    assign chk_s[1] = chk_rb;
    assign chk_s[2] = chk_rc;

    // Hazard lookup over stages 1..LATENCY-1; the writeback slot is already visible.
    always_comb begin
        haz_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            haz_s[i] = s1_valid_r & s1_wr_r & (s1_rt_r == chk_s[i]);
            for (int k = 2; k < LATENCY; k++) begin
                haz_s[i] = haz_s[i] | stage_hit(stg_q_s[k], chk_s[i]);
            end
        end
    end

    assign haz = haz_s;

    // Occupancy bookkeeping: +accept, -retire, -killed.
    always_comb begin
        killed_s = 3'd0;
        if (flush) begin
            killed_s = {2'b00, s1_valid_r};
            for (int k = 2; k < LATENCY; k++) begin
                killed_s = killed_s + {2'b00, stage_live(stg_q_s[k])};
            end
        end else begin
            killed_s = 3'd0;
        end
        retire_s       = {2'b00, wb_s.valid & ~hold_s};
        inflight_nxt_s = inflight_r + {2'b00, accept_s} - retire_s - killed_s;
    end

    // Registered occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 3'd0;
        end else begin
            inflight_r <= inflight_nxt_s;
        end
    end

    assign inflight = inflight_r;

endmodule
